// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control definitions: stall encodings, exception codes and the
// exception vector, used by every stage that reasons about hold/flush.
package pipeline_ctrl_pkg;

   localparam logic STOP     = 1'b1;
   localparam logic NOT_STOP = 1'b0;

   // Stall masks, bit0 PC .. bit5 WB; a request holds its own stage and all upstream ones.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;
   localparam logic [5:0] STALL_ALL  = 6'b111111;

   localparam logic [31:0] EXC_NONE   = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET   = 32'h0000_000E;
   localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

   // ERET returns to EPC; every other exception enters the common handler.
   function automatic logic [31:0] exc_target(input logic [31:0] code, input logic [31:0] epc);
      return (code == EXC_ERET) ? epc : EXC_VECTOR;
   endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline hold/flush controller: prioritised stage stalls, exception redirect that
// waits for any outstanding bus transaction, and a saturating stall-cycle counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] exception_type,
   input  logic [31:0] cp0_epc,
   input  logic        bus_busy,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_BUS = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] exc_code_q, epc_q;
   logic        latch_en;
   logic [31:0] cnt_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_comb begin
      state_d  = state_q;
      stall    = STALL_NONE;
      flush    = 1'b0;
      new_pc   = 32'h0;
      latch_en = 1'b0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (exception_type != EXC_NONE) begin
                  // A redirect cannot be taken while a bus response is still owed.
                  if (bus_busy) begin
                     stall    = STALL_ALL;
                     latch_en = 1'b1;
                     state_d  = WAIT_BUS;
                  end else begin
                     flush   = 1'b1;
                     new_pc  = exc_target(exception_type, cp0_epc);
                     state_d = FLUSH;
                  end
               end else if (stallreq_mem) begin
                  stall = STALL_MEM;
               end else if (stallreq_ex) begin
                  stall = STALL_EX;
               end else if (stallreq_id) begin
                  stall = STALL_ID;
               end else if (stallreq_if) begin
                  stall = STALL_IF;
               end
            end
            WAIT_BUS: begin
               if (bus_busy) begin
                  stall = STALL_ALL;
               end else begin
                  flush   = 1'b1;
                  new_pc  = exc_target(exc_code_q, epc_q);
                  state_d = FLUSH;
               end
            end
            FLUSH: begin
               state_d = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         exc_code_q <= 32'h0;
         epc_q      <= 32'h0;
         cnt_q      <= 32'h0;
      end else begin
         state_q <= state_d;
         if (latch_en) begin
            exc_code_q <= exception_type;
            epc_q      <= cp0_epc;
         end
         if (stall[0] == STOP) begin
            cnt_q <= sat_inc(cnt_q);
         end
      end
   end

   assign stall_cycles = cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have stallreq_if  input  1  fetch stage waiting on instruction bus.
REQ-004 SHALL have stallreq_id  input  1  decode load-use hazard.
REQ-005 SHALL have stallreq_ex  input  1  execute multi-cycle op (div/madd) busy.
REQ-006 SHALL have stallreq_mem  input  1  memory stage waiting on data bus.
REQ-007 SHALL have exception_type  input  32  exception code from MEM stage; 0 = none.
REQ-008 SHALL have cp0_epc  input  32  current EPC from CP0.
REQ-009 SHALL have bus_busy  input  1  AXI transaction outstanding (address issued, response not received).
REQ-010 SHALL have stall  output  6  per-stage hold, bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = STOP.
REQ-011 SHALL have flush  output  1  one-cycle pipeline flush pulse.
REQ-012 SHALL have new_pc  output  32  redirect target, valid only while flush=1, else 0.
REQ-013 SHALL have stall_cycles  output  32  saturating count of cycles with stall[0]=1.

Function
REQ-014 SHALL implement FSM states RUN, WAIT_BUS, FLUSH.
REQ-015 In RUN with exception_type=0, stall SHALL be combinational by priority: stallreq_mem -> 6'b011111, else stallreq_ex -> 6'b001111, else stallreq_id -> 6'b000111, else stallreq_if -> 6'b000011, else 6'b000000; flush=0.
REQ-016 In RUN with exception_type!=0 and bus_busy=0, flush SHALL be 1 in the same cycle, stall=0, new_pc per REQ-019; next state FLUSH.
REQ-017 In RUN with exception_type!=0 and bus_busy=1, flush=0, stall=6'b111111, exception_type and cp0_epc SHALL be latched; next state WAIT_BUS.
REQ-018 In WAIT_BUS, stall SHALL be 6'b111111 while bus_busy=1; in the first cycle bus_busy=0, flush=1, stall=0, new_pc from latched values; next state FLUSH. Live inputs ignored in WAIT_BUS.
REQ-019 new_pc SHALL be EPC (live in RUN, latched in WAIT_BUS) when code=32'h0000000E (ERET), else 32'hBFC00380.
REQ-020 In FLUSH (exactly one cycle), flush=0, stall=0, exception_type and stall requests ignored; next state RUN.
REQ-021 Simultaneous exception and stall requests: exception SHALL win; stall requests ignored that cycle.
REQ-022 stall_cycles SHALL increment by 1 each cycle stall[0]=1 and hold at 32'hFFFFFFFF.
REQ-023 Outputs stall, flush, new_pc SHALL be combinational from state, latches and inputs; no extra latency.

Reset
REQ-024 While rst=1, stall=0, flush=0, new_pc=0 combinationally; on the edge, state<=RUN, latches<=0, stall_cycles<=0.
REQ-025 Reset asserted in WAIT_BUS or FLUSH SHALL discard the pending exception.

Structure
REQ-026 Stall encodings, STOP/NOT_STOP, exception codes (ERET 32'h0000000E) and exception vector 32'hBFC00380 SHALL live in the shared global define package.
REQ-027 FSM state encoding SHALL be local; no sub-module.

Verification
REQ-028 stallreq_id=1 and stallreq_mem=1 -> stall=6'b011111; stall_cycles +1.
REQ-029 exception_type=32'h00000008, bus_busy=0 -> flush=1 same cycle, new_pc=32'hBFC00380; next cycle flush=0, stall=0.
REQ-030 exception_type=32'h0000000E, cp0_epc=32'h80001234, bus_busy=1 for 3 cycles -> stall=6'b111111 for 3 cycles, then flush=1, new_pc=32'h80001234 even if cp0_epc changed.
REQ-031 Exception with stallreq_ex=1 in the same cycle -> flush=1, stall=0.
REQ-032 rst=1 in WAIT_BUS -> flush never asserts; state RUN; stall_cycles=0.
REQ-033 Force stall_cycles to 32'hFFFFFFFE, hold stallreq_if=1 for 3 cycles -> counter reaches 32'hFFFFFFFF and holds.
